// File: rtl/kamacore_pkg.sv
// Shared core definitions: widths, control-transfer opcodes, branch funct3 codes and
// the 2-bit saturating counter type used by the branch history table.
package kamacore_pkg;

  localparam int CPU_WIDTH = 32;

  localparam logic [6:0] OPCODE_SB_TYPE = 7'b1100011;
  localparam logic [6:0] OPCODE_JAL     = 7'b1101111;
  localparam logic [6:0] OPCODE_JALR    = 7'b1100111;

  // 3'b010 and 3'b011 are deliberately absent: they are not branches.
  typedef enum logic [2:0] {
    F3_BEQ  = 3'b000,
    F3_BNE  = 3'b001,
    F3_BLT  = 3'b100,
    F3_BGE  = 3'b101,
    F3_BLTU = 3'b110,
    F3_BGEU = 3'b111
  } branch_funct3_e;

  typedef logic [1:0] bht_ctr_t;

  localparam bht_ctr_t BHT_INIT = 2'b01;

  function automatic bht_ctr_t bht_next(input bht_ctr_t ctr, input logic taken);
    bht_ctr_t res;
    res = ctr;
    if (taken && ctr != 2'b11) res = ctr + 2'b01;
    else if (!taken && ctr != 2'b00) res = ctr - 2'b01;
    return res;
  endfunction

endpackage

// File: rtl/branch_history_table.sv
// Table of 2-bit saturating direction counters: one asynchronous read port for fetch
// lookup, one saturating update port written at the clock edge.
module branch_history_table
  import kamacore_pkg::*;
#(
  parameter int BHT_DEPTH = 64,
  parameter int IDX_W     = $clog2(BHT_DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IDX_W-1:0] rd_idx,
  output bht_ctr_t         rd_ctr,
  input  logic             upd_en,
  input  logic [IDX_W-1:0] upd_idx,
  input  logic             upd_taken
);

  bht_ctr_t ctr_q [BHT_DEPTH];

  // NOTE: this table is built from flops, not a RAM macro, because every entry must
  // return to weakly-not-taken on reset; a RAM could not be cleared in one edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BHT_DEPTH; i++) ctr_q[i] <= BHT_INIT;
    end else if (upd_en) begin
      ctr_q[upd_idx] <= bht_next(ctr_q[upd_idx], upd_taken);
    end
  end

  // Read sees the pre-update value when read and update hit the same index.
  assign rd_ctr = ctr_q[rd_idx];

endmodule

// File: rtl/branch_resolve_unit.sv
// One-stage registered branch resolver (B-type, JAL, JALR) with valid/ready on both sides
// and a BHT for fetch prediction. Define BRANCH_STATS_EN to add CTI/mispredict counters.
module branch_resolve_unit
  import kamacore_pkg::*;
#(
  parameter int XLEN      = CPU_WIDTH,
  parameter int BHT_DEPTH = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_pc,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_rs1,
  input  logic [XLEN-1:0] in_rs2,
  input  logic            in_pred_taken,
  input  logic [XLEN-1:0] in_pred_target,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            out_is_cti,
  output logic            out_taken,
  output logic [XLEN-1:0] out_target,
  output logic [XLEN-1:0] out_next_pc,
  output logic            out_mispredict,
  input  logic [XLEN-1:0] lookup_pc,
  output logic            lookup_taken
`ifdef BRANCH_STATS_EN
  ,
  output logic [31:0]     stat_cti,
  output logic [31:0]     stat_mispredict
`endif
);

  localparam int IDX_W = $clog2(BHT_DEPTH);

  typedef struct packed {
    logic             is_cti;
    logic             is_btype;
    logic             taken;
    logic             mispredict;
    logic [IDX_W-1:0] bht_idx;
    logic [XLEN-1:0]  target;
    logic [XLEN-1:0]  next_pc;
  } result_t;

  result_t         res_d, res_q;
  logic            valid_q;
  logic            accept, out_fire;
  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [XLEN-1:0] imm_b, imm_j, imm_i, pc_plus4;
  logic            br_legal, br_cond;
  bht_ctr_t        lookup_ctr;

  assign opcode   = in_instr[6:0];
  assign funct3   = in_instr[14:12];
  assign imm_b    = {{(XLEN-13){in_instr[31]}}, in_instr[31], in_instr[7],
                     in_instr[30:25], in_instr[11:8], 1'b0};
  assign imm_j    = {{(XLEN-21){in_instr[31]}}, in_instr[31], in_instr[19:12],
                     in_instr[20], in_instr[30:21], 1'b0};
  assign imm_i    = {{(XLEN-12){in_instr[31]}}, in_instr[31:20]};
  assign pc_plus4 = in_pc + XLEN'(4);

  // NOTE: every signal written here gets a value before any branch of the case, so no
  // path leaves one unassigned and no latch is inferred.
  always_comb begin
    res_d    = '0;
    br_legal = 1'b1;
    br_cond  = 1'b0;
    case (funct3)
      F3_BEQ:  br_cond = (in_rs1 == in_rs2);
      F3_BNE:  br_cond = (in_rs1 != in_rs2);
      F3_BLT:  br_cond = ($signed(in_rs1) <  $signed(in_rs2));
      F3_BGE:  br_cond = ($signed(in_rs1) >= $signed(in_rs2));
      F3_BLTU: br_cond = (in_rs1 <  in_rs2);
      F3_BGEU: br_cond = (in_rs1 >= in_rs2);
      default: br_legal = 1'b0;
    endcase

    res_d.bht_idx = in_pc[IDX_W+1:2];
    case (opcode)
      OPCODE_SB_TYPE: begin
        if (br_legal) begin
          res_d.is_cti   = 1'b1;
          res_d.is_btype = 1'b1;
          res_d.taken    = br_cond;
          res_d.target   = in_pc + imm_b;
        end
      end
      OPCODE_JAL: begin
        res_d.is_cti = 1'b1;
        res_d.taken  = 1'b1;
        res_d.target = in_pc + imm_j;
      end
      OPCODE_JALR: begin
        if (funct3 == 3'b000) begin
          res_d.is_cti = 1'b1;
          res_d.taken  = 1'b1;
          res_d.target = (in_rs1 + imm_i) & ~XLEN'(1);
        end
      end
      default: ;
    endcase

    res_d.next_pc    = res_d.taken ? res_d.target : pc_plus4;
    // A non-CTI that fetch predicted taken still needs a redirect back to pc+4.
    res_d.mispredict = res_d.is_cti
                     ? ((res_d.taken != in_pred_taken) ||
                        (res_d.taken && (res_d.target != in_pred_target)))
                     : in_pred_taken;
  end

  assign in_ready = !valid_q || out_ready;
  assign accept   = in_valid && in_ready;
  assign out_fire = valid_q && out_ready;

  // NOTE: state registers use non-blocking assignments so every flop samples the
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      res_q   <= '0;
    end else if (flush) begin
      valid_q <= 1'b0;
    end else if (accept) begin
      valid_q <= 1'b1;
      res_q   <= res_d;
    end else if (out_ready) begin
      valid_q <= 1'b0;
    end
  end

  assign out_valid      = valid_q;
  assign out_is_cti     = res_q.is_cti;
  assign out_taken      = res_q.taken;
  assign out_target     = res_q.target;
  assign out_next_pc    = res_q.next_pc;
  assign out_mispredict = res_q.mispredict;

  // Training happens on the output handshake, so a flush in the same cycle does not stop it.
  branch_history_table #(
    .BHT_DEPTH (BHT_DEPTH),
    .IDX_W     (IDX_W)
  ) u_bht (
    .clk       (clk),
    .rst_n     (rst_n),
    .rd_idx    (lookup_pc[IDX_W+1:2]),
    .rd_ctr    (lookup_ctr),
    .upd_en    (out_fire && res_q.is_btype),
    .upd_idx   (res_q.bht_idx),
    .upd_taken (res_q.taken)
  );

  assign lookup_taken = lookup_ctr[1];

  logic unused_bits;
  assign unused_bits = ^{lookup_pc[XLEN-1:IDX_W+2], lookup_pc[1:0], lookup_ctr[0]};

`ifdef BRANCH_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_cti        <= '0;
      stat_mispredict <= '0;
    end else if (out_fire) begin
      stat_cti        <= stat_cti + 32'(res_q.is_cti);
      stat_mispredict <= stat_mispredict + 32'(res_q.mispredict);
    end
  end
`endif

endmodule
